act_mem_ctrl: RTL and testbench

Activation-memory read sequencer between the top controller and the PE activation register file. On each `act_load` pulse it streams one channel-group slab of 18×18 activation words from the double-banked activation BRAM into the PE. The words are tagged with a rotating 3-row select and a column index. It absorbs the 1-cycle BRAM read latency with a 1-entry skid buffer, so PE back-pressure never drops or duplicates a word.

---
 rtl/vgg_acc_pkg.sv | 27 ++
 rtl/act_mem_ctrl_if.sv | 31 +++
 rtl/act_skid_buf.sv | 68 ++++++
 rtl/act_mem_ctrl.sv | 145 ++++++++++++++
 tb/tb_act_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vgg_acc_pkg.sv
// Shared types and constants for the accelerator activation path.
// Slab geometry, act-memory sequencer states and PE row-select codes.
package vgg_acc_pkg;

    localparam int ROW_W  = 18;
    localparam int N_ROW  = 18;
    localparam int SLAB   = ROW_W * N_ROW;
    localparam int ACT_DW = 512;

    typedef enum logic [1:0] {
        ACT_IDLE  = 2'd0,
        ACT_ISSUE = 2'd1,
        ACT_DRAIN = 2'd2,
        ACT_DONE  = 2'd3
    } act_state_e;

    localparam logic [2:0] ROW_SEL_0    = 3'b100;
    localparam logic [2:0] ROW_SEL_1    = 3'b010;
    localparam logic [2:0] ROW_SEL_2    = 3'b001;
    localparam logic [2:0] ROW_SEL_NONE = 3'b000;

    // Rotates 100 -> 010 -> 001 -> 100 as the output moves to the next row.
    function automatic logic [2:0] next_row_sel(input logic [2:0] sel);
        return {sel[0], sel[2:1]};
    endfunction

endpackage

// File: rtl/act_mem_ctrl_if.sv
// Bus bundle between the activation sequencer, the activation BRAM and the PE register file.
interface act_mem_ctrl_if
    import vgg_acc_pkg::*;
#(
    parameter int DW = ACT_DW,
    parameter int AW = 15
);
    logic [AW-1:0] act_mem_addr;
    logic          en_act_mem;
    logic [DW-1:0] act_mem_dout;

    // rf_valid/rf_ready: a word transfers in every cycle where both are high; once rf_valid
    // rises it and rf_data/rf_row_sel/rf_col/rf_last stay fixed until that transfer happens.
    logic [DW-1:0] rf_data;
    logic          rf_valid;
    logic          rf_ready;
    logic [2:0]    rf_row_sel;
    logic [4:0]    rf_col;
    logic          rf_last;

    modport master (
        output act_mem_addr, en_act_mem, rf_data, rf_valid, rf_row_sel, rf_col, rf_last,
        input  act_mem_dout, rf_ready
    );

    modport slave (
        input  act_mem_addr, en_act_mem, rf_data, rf_valid, rf_row_sel, rf_col, rf_last,
        output act_mem_dout, rf_ready
    );

endinterface

// File: rtl/act_skid_buf.sv
// One-entry output register plus skid slot that absorbs the word already in flight
// from the BRAM when the PE stalls.
module act_skid_buf #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    output logic          skid_full_o
);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          out_free;

    assign out_free = !out_valid_q || out_ready_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_free) begin
            // The older skid word always goes out first to keep issue order.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_valid_i;
                if (in_valid_i) begin
                    skid_data_d = in_data_i;
                end
            end else begin
                out_valid_d = in_valid_i;
                if (in_valid_i) begin
                    out_data_d = in_data_i;
                end
            end
        end else if (in_valid_i) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign skid_full_o = skid_valid_q;

endmodule

// File: rtl/act_mem_ctrl.sv
// Activation-memory read sequencer: streams one 18x18 channel-group slab from the
// double-banked activation BRAM into the PE register file, tagged with row select and column.
module act_mem_ctrl
    import vgg_acc_pkg::*;
#(
    parameter int DW    = ACT_DW,
    parameter int ROW_W = vgg_acc_pkg::ROW_W,
    parameter int N_ROW = vgg_acc_pkg::N_ROW,
    parameter int AW    = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           act_load,
    input  logic [5:0]     ch,
    input  logic [8:0]     tile,
    act_mem_ctrl_if.master bus,
    output logic           busy,
    output logic           done,
    output act_state_e     dbg_state_o
);

    localparam int OFF_W  = AW - 1;
    localparam int SLAB_N = ROW_W * N_ROW;
    localparam int CW     = 5;

    act_state_e      state_q, state_d;
    logic [5:0]      ch_q, ch_d;
    logic            bank_q, bank_d;
    logic [CW-1:0]   rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic [CW-1:0]   out_row_q, out_row_d, out_col_q, out_col_d;
    logic [2:0]      row_sel_q, row_sel_d;
    logic            rd_pend_q, rd_pend_d;

    logic            skid_full, rf_valid, rf_ready;
    logic            issue, hs, rd_last, out_last;
    logic [OFF_W-1:0] rd_off;
    logic            unused_tile;

    assign unused_tile = ^tile[8:1];
    assign rf_ready    = bus.rf_ready;

    act_skid_buf #(.DW(DW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_pend_q),
        .in_data_i   (bus.act_mem_dout),
        .out_ready_i (rf_ready),
        .out_valid_o (rf_valid),
        .out_data_o  (bus.rf_data),
        .skid_full_o (skid_full)
    );

    // Issuing only when the returning word is guaranteed a slot keeps one read in flight.
    assign issue    = (state_q == ACT_ISSUE) && !skid_full && (!rf_valid || rf_ready);
    assign hs       = rf_valid && rf_ready;
    assign rd_last  = (rd_row_q == CW'(N_ROW - 1)) && (rd_col_q == CW'(ROW_W - 1));
    assign out_last = (out_row_q == CW'(N_ROW - 1)) && (out_col_q == CW'(ROW_W - 1));
    assign rd_off   = OFF_W'(int'(ch_q) * SLAB_N + int'(rd_row_q) * ROW_W + int'(rd_col_q));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        bank_d    = bank_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        row_sel_d = row_sel_q;
        rd_pend_d = issue;

        if (issue) begin
            if (rd_col_q == CW'(ROW_W - 1)) begin
                rd_col_d = '0;
                rd_row_d = rd_row_q + CW'(1);
            end else begin
                rd_col_d = rd_col_q + CW'(1);
            end
        end

        if (hs) begin
            if (out_col_q == CW'(ROW_W - 1)) begin
                out_col_d = '0;
                out_row_d = out_last ? '0 : out_row_q + CW'(1);
                row_sel_d = next_row_sel(row_sel_q);
            end else begin
                out_col_d = out_col_q + CW'(1);
            end
        end

        case (state_q)
            ACT_IDLE: begin
                if (act_load) begin
                    state_d   = ACT_ISSUE;
                    ch_d      = ch;
                    bank_d    = tile[0];
                    rd_row_d  = '0;
                    rd_col_d  = '0;
                    out_row_d = '0;
                    out_col_d = '0;
                    row_sel_d = ROW_SEL_0;
                end
            end
            ACT_ISSUE: if (issue && rd_last) state_d = ACT_DRAIN;
            ACT_DRAIN: if (hs && out_last) state_d = ACT_DONE;
            ACT_DONE:  state_d = ACT_IDLE;
            default:   state_d = ACT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACT_IDLE;
            ch_q      <= '0;
            bank_q    <= 1'b0;
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
            row_sel_q <= ROW_SEL_NONE;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            bank_q    <= bank_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
            row_sel_q <= row_sel_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.en_act_mem   = issue;
    assign bus.act_mem_addr = issue ? {bank_q, rd_off} : '0;
    assign bus.rf_valid     = rf_valid;
    assign bus.rf_col       = out_col_q;
    assign bus.rf_row_sel   = rf_valid ? row_sel_q : ROW_SEL_NONE;
    assign bus.rf_last      = rf_valid && out_last;

    assign busy        = (state_q != ACT_IDLE);
    assign done        = (state_q == ACT_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_act_mem_ctrl.sv
// Bench for act_mem_ctrl: BRAM model with hashed contents, randomized PE back-pressure,
// and a slab-level reference (address list and word queue) built from the address formula.
module tb_act_mem_ctrl;
    import vgg_acc_pkg::*;

    localparam int DW = 512;
    localparam int AW = 15;
    localparam int NW = 324;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       act_load = 1'b0;
    logic [5:0] ch = '0;
    logic [8:0] tile = '0;
    logic       busy, done;
    act_state_e dbg_state;
    logic [31:0] seed;

    int n_tests = 0;
    int n_fail  = 0;

    act_mem_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    act_mem_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .act_load    (act_load),
        .ch          (ch),
        .tile        (tile),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) begin
            w[j*32 +: 32] = ({17'd0, a} * 32'h9E3779B1) ^ (32'(j) * 32'h85EBCA6B) ^ seed;
        end
        return w;
    endfunction

    // Synchronous-read BRAM: data appears the cycle after the enable.
    always @(posedge clk) begin
        if (bus.en_act_mem) bus.act_mem_dout <= bram_word(bus.act_mem_addr);
    end

    task automatic check_all_zero(input string name);
        n_tests++;
        if (bus.en_act_mem !== 1'b0 || bus.act_mem_addr !== '0 || bus.rf_valid !== 1'b0 ||
            bus.rf_data !== '0 || bus.rf_row_sel !== 3'b000 || bus.rf_col !== 5'd0 ||
            bus.rf_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== ACT_IDLE) begin
            n_fail++;
            $display("FAIL %s: en=%b addr=%h valid=%b sel=%b col=%0d last=%b busy=%b done=%b state=%0d, expected all 0",
                     name, bus.en_act_mem, bus.act_mem_addr, bus.rf_valid, bus.rf_row_sel,
                     bus.rf_col, bus.rf_last, busy, done, dbg_state);
        end
    endtask

    // mode 0: ready always 1; 1: 1,0,0,1 pattern plus a 20-cycle hold at word 100; 2: random.
    task automatic run_slab(input logic [5:0] c, input logic [8:0] t, input int mode,
                            input bit inject, input bit aligned, input int abort_at, input string name);
        logic [AW-1:0] exp_addr_q[$];
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        logic [DW-1:0] prev_data;
        logic [2:0]    prev_sel, exp_sel;
        logic [4:0]    prev_col;
        logic          prev_last;
        int k, n_hs, n_en, first_en, first_valid, last_cyc, done_cyc, hold_left;
        bit hold_done, prev_stall, finished, r;

        for (int i = 0; i < NW; i++) begin
            ea = {t[0], 14'(int'(c) * NW + i)};
            exp_addr_q.push_back(ea);
            exp_q.push_back(bram_word(ea));
        end
        k = 0; n_hs = 0; n_en = 0; first_en = -1; first_valid = -1;
        last_cyc = -1; done_cyc = -1; hold_left = 0;
        hold_done = 0; prev_stall = 0; finished = 0;
        prev_data = '0; prev_sel = '0; prev_col = '0; prev_last = 1'b0;

        if (!aligned) begin
            @(posedge clk);
            #1;
        end
        act_load = 1'b1;
        ch = c;
        tile = t;
        bus.rf_ready = (mode == 0);
        if (!aligned) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_c0: got %b want 0", name, busy);
        end

        while (!finished) begin
            @(posedge clk);
            #1;
            k++;
            act_load = inject && (k == 50 || k == 327);
            if (act_load) begin
                ch = 6'($urandom);
                tile = 9'($urandom);
            end
            case (mode)
                0: r = 1'b1;
                1: begin
                    if (hold_left > 0) begin
                        hold_left--;
                        r = 1'b0;
                    end else if (n_hs == 100 && !hold_done) begin
                        hold_done = 1;
                        hold_left = 19;
                        r = 1'b0;
                    end else begin
                        r = (k % 4 == 0) || (k % 4 == 3);
                    end
                end
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            bus.rf_ready = r;

            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero({name, " async_reset"});
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    n_tests++;
                    if (done !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s reset_hold: done=%b busy=%b want 0 0", name, done, busy);
                    end
                end
                rst_n = 1'b1;
                return;
            end

            @(negedge clk);
            if (bus.en_act_mem) begin
                if (first_en < 0) first_en = k;
                n_en++;
                n_tests++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s addr_extra: cycle %0d addr=%h, no read expected", name, k, bus.act_mem_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (bus.act_mem_addr !== ea) begin
                        n_fail++;
                        $display("FAIL %s addr: cycle %0d got %h want %h", name, k, bus.act_mem_addr, ea);
                    end
                end
            end

            if (prev_stall) begin
                n_tests++;
                if (bus.rf_valid !== 1'b1 || bus.rf_data !== prev_data || bus.rf_row_sel !== prev_sel ||
                    bus.rf_col !== prev_col || bus.rf_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL %s hold: cycle %0d valid=%b sel=%b col=%0d last=%b want 1 %b %0d %b",
                             name, k, bus.rf_valid, bus.rf_row_sel, bus.rf_col, bus.rf_last,
                             prev_sel, prev_col, prev_last);
                end
            end

            if (bus.rf_valid === 1'b1) begin
                if (first_valid < 0) first_valid = k;
                case ((n_hs / 18) % 3)
                    0: exp_sel = 3'b100;
                    1: exp_sel = 3'b010;
                    default: exp_sel = 3'b001;
                endcase
                n_tests++;
                if (bus.rf_row_sel !== exp_sel || bus.rf_col !== 5'(n_hs % 18) ||
                    bus.rf_last !== (n_hs == NW - 1)) begin
                    n_fail++;
                    $display("FAIL %s tag: word %0d sel=%b col=%0d last=%b want %b %0d %b",
                             name, n_hs, bus.rf_row_sel, bus.rf_col, bus.rf_last,
                             exp_sel, n_hs % 18, (n_hs == NW - 1));
                end
                if (bus.rf_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s word_extra: cycle %0d unexpected handshake", name, k);
                    end else begin
                        ew = exp_q.pop_front();
                        if (bus.rf_data !== ew) begin
                            n_fail++;
                            $display("FAIL %s data: word %0d got %h want %h", name, n_hs, bus.rf_data, ew);
                        end
                    end
                    if (bus.rf_last === 1'b1) last_cyc = k;
                    n_hs++;
                end
            end else begin
                n_tests++;
                if (bus.rf_row_sel !== 3'b000 || bus.rf_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s idle_tag: cycle %0d sel=%b last=%b want 000 0", name, k, bus.rf_row_sel, bus.rf_last);
                end
            end
            prev_stall = (bus.rf_valid === 1'b1) && !bus.rf_ready;
            prev_data  = bus.rf_data;
            prev_sel   = bus.rf_row_sel;
            prev_col   = bus.rf_col;
            prev_last  = bus.rf_last;

            if (done_cyc >= 0) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0 || dbg_state !== ACT_IDLE) begin
                    n_fail++;
                    $display("FAIL %s post_done: busy=%b done=%b state=%0d want 0 0 IDLE", name, busy, done, dbg_state);
                end
                finished = 1;
            end else begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy: cycle %0d got %b want 1", name, k, busy);
                end
                if (done === 1'b1) done_cyc = k;
            end

            if (k > 3000 && !finished) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: no done after %0d cycles, %0d words", name, k, n_hs);
                finished = 1;
            end
        end
        act_load = 1'b0;

        n_tests++;
        if (n_hs != NW || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d want %0d", name, n_hs, NW);
        end
        n_tests++;
        if (n_en != NW) begin
            n_fail++;
            $display("FAIL %s read_count: got %0d want %0d", name, n_en, NW);
        end
        n_tests++;
        if (done_cyc != last_cyc + 1 || done_cyc < 0) begin
            n_fail++;
            $display("FAIL %s done_after_last: done %0d last %0d want done = last+1", name, done_cyc, last_cyc);
        end
        if (mode == 0) begin
            n_tests++;
            if (first_en != 1 || first_valid != 3 || last_cyc != 326 || done_cyc != 327) begin
                n_fail++;
                $display("FAIL %s timing: en %0d valid %0d last %0d done %0d want 1 3 326 327",
                         name, first_en, first_valid, last_cyc, done_cyc);
            end
        end
    endtask

    task automatic test_reset();
        bus.rf_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    task automatic test_basic_slab();
        run_slab(6'd0, 9'd1, 0, 1'b0, 1'b0, -1, "basic");
    endtask

    task automatic test_max_channel();
        run_slab(6'd44, 9'd2, 0, 1'b0, 1'b0, -1, "max_ch");
    endtask

    task automatic test_back_pressure();
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 1, 1'b0, 1'b0, -1, "bp_pattern");
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 2, 1'b0, 1'b0, -1, "bp_random");
    endtask

    task automatic test_ignored_load();
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 0, 1'b1, 1'b0, -1, "ignored_load");
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 0, 1'b0, 1'b1, -1, "back_to_back");
    endtask

    task automatic test_reset_mid_slab();
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 0, 1'b0, 1'b0, 100, "abort");
        run_slab(6'($urandom_range(0, 44)), 9'($urandom), 0, 1'b0, 1'b0, -1, "restart");
    endtask

    initial begin
        seed = $urandom;
        bus.rf_ready = 1'b0;
        test_reset();
        test_basic_slab();
        test_max_channel();
        test_back_pressure();
        test_ignored_load();
        test_reset_mid_slab();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
